bcd_arb_ctrl: RTL

BCD_ARB_CTRL -- requirements
Module: bcd_arb_ctrl

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_dabble_step.sv | 23 ++
 rtl/bcd_arb_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the two-requester binary-to-BCD converter.
package bcd_pkg;

  localparam int WIDTH     = 8;
  localparam int DIGITS    = 3;
  localparam int SHIFT_CNT = 8;
  localparam int WORK_W    = WIDTH + 4 * DIGITS;  // 20-bit double-dabble register
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD field >= 5, then shift left by one.
module bcd_dabble_step
  import bcd_pkg::*;
(
  input  logic [WORK_W-1:0] work_i,
  output logic [WORK_W-1:0] work_o
);

  logic [WORK_W-1:0] adj;

  // Digit fields sit above the binary operand, lowest digit first.
  always_comb begin
    adj = work_i;
    for (int d = 0; d < DIGITS; d++) begin
      if (work_i[WIDTH + 4*d +: 4] >= 4'd5) begin
        adj[WIDTH + 4*d +: 4] = work_i[WIDTH + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign work_o = {adj[WORK_W-2:0], 1'b0};

endmodule

// File: rtl/bcd_arb_ctrl.sv
// Round-robin arbiter in front of a sequential 8-bit binary-to-BCD converter.
module bcd_arb_ctrl
  import bcd_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] bin0,
  input  logic [WIDTH-1:0] bin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [3:0]       hund,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  state_e              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [WORK_W-1:0]   step_out;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_id_q, last_id_d;
  logic                gnt_id_q, gnt_id_d;
  logic                done_id_q, done_id_d;
  logic [3:0]          hund_q, hund_d;
  logic [3:0]          tens_q, tens_d;
  logic [3:0]          ones_q, ones_d;
  logic                win_id;
  logic                last_shift;

  // On a tie the requester not served last wins; a lone request always wins.
  assign win_id     = (req0 && req1) ? ~last_id_q : req1;
  assign last_shift = (cnt_q == CNT_W'(SHIFT_CNT - 1));

  bcd_dabble_step u_step (
    .work_i (work_q),
    .work_o (step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req0 || req1) state_d = ST_GRANT;
      ST_GRANT: state_d = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt0 = (state_q == ST_GRANT) && !gnt_id_q;
    gnt1 = (state_q == ST_GRANT) &&  gnt_id_q;
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    work_d    = work_q;
    cnt_d     = cnt_q;
    last_id_d = last_id_q;
    gnt_id_d  = gnt_id_q;
    done_id_d = done_id_q;
    hund_d    = hund_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          work_d    = {{(WORK_W-WIDTH){1'b0}}, (win_id ? bin1 : bin0)};
          gnt_id_d  = win_id;
          last_id_d = win_id;
        end
      end
      ST_GRANT: cnt_d = '0;
      ST_SHIFT: begin
        work_d = step_out;
        cnt_d  = cnt_q + 1'b1;
        // Results are taken from the final shifted value so they land with DONE.
        if (last_shift) begin
          hund_d    = step_out[19:16];
          tens_d    = step_out[15:12];
          ones_d    = step_out[11:8];
          done_id_d = gnt_id_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_q    <= '0;
      cnt_q     <= '0;
      last_id_q <= 1'b1;
      gnt_id_q  <= 1'b0;
      done_id_q <= 1'b0;
      hund_q    <= '0;
      tens_q    <= '0;
      ones_q    <= '0;
    end else begin
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      last_id_q <= last_id_d;
      gnt_id_q  <= gnt_id_d;
      done_id_q <= done_id_d;
      hund_q    <= hund_d;
      tens_q    <= tens_d;
      ones_q    <= ones_d;
    end
  end

  assign done_id = done_id_q;
  assign hund    = hund_q;
  assign tens    = tens_q;
  assign ones    = ones_q;

endmodule
